// File: rtl/ad_pll_supervisor.sv
// ad_pll_supervisor
//   Sequences the ADC-clock PLL: pulses its reset, waits for a stable lock,
//   then releases the ADC-domain reset. Loss of lock in RUN re-arms the PLL;
//   repeated lock timeouts park the block in FAIL until clr_fail.
// Ports
//   clkin1    board clock (50 MHz), sole clock
//   rst       synchronous active-high reset
//   pll_lock  PLL LOCK, asynchronous to clkin1
//   clr_fail  one-cycle pulse, leaves FAIL
//   pll_rst   PLL reset (high in RESET_PLL and FAIL)
//   ad_rst    ADC-domain reset (low only in RUN)
//   lock_ok   high only in RUN
//   fail      high only in FAIL
//   state     encoded state (RESET_PLL=0 WAIT_LOCK=1 SETTLE=2 RUN=3 FAIL=4)
//   lost_cnt  saturating count of lock losses in RUN
module ad_pll_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned DROP_FILTER   = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       clr_fail,
    output logic       pll_rst,
    output logic       ad_rst,
    output logic       lock_ok,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] lost_cnt
);

    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    localparam int unsigned RST_W   = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int unsigned TO_W    = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned DROP_W  = (DROP_FILTER   > 1) ? $clog2(DROP_FILTER)   : 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    logic               sync_q;
    logic               lock_s;
    logic [RST_W-1:0]   rst_cnt,   rst_cnt_nxt;
    logic [TO_W-1:0]    to_cnt,    to_cnt_nxt;
    logic [SET_W-1:0]   set_cnt,   set_cnt_nxt;
    logic [DROP_W-1:0]  drop_cnt,  drop_cnt_nxt;
    logic [RETRY_W-1:0] retry,     retry_nxt;
    logic [7:0]         lost_nxt;
    logic [2:0]         state_nxt;
    logic               timeout;
    logic               pll_rst_nxt, ad_rst_nxt, lock_ok_nxt, fail_nxt;

    // Next-state, counter and output decode
    always_comb begin
        state_nxt    = state;
        rst_cnt_nxt  = '0;
        to_cnt_nxt   = to_cnt;
        set_cnt_nxt  = '0;
        drop_cnt_nxt = '0;
        retry_nxt    = retry;
        lost_nxt     = lost_cnt;
        timeout      = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));

        case (state)
            ST_RESET_PLL: begin
                to_cnt_nxt = '0;
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_nxt = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end
            ST_WAIT_LOCK, ST_SETTLE: begin
                // Timeout wins over lock progress, including settle completion
                if (timeout) begin
                    to_cnt_nxt = '0;
                    retry_nxt  = retry + RETRY_W'(1);
                    state_nxt  = (retry_nxt == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RESET_PLL;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    if (state == ST_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_nxt = ST_SETTLE;
                        end
                    end else if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (set_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                    end else begin
                        set_cnt_nxt = set_cnt + SET_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    if (drop_cnt == DROP_W'(DROP_FILTER - 1)) begin
                        state_nxt = ST_RESET_PLL;
                        if (lost_cnt != 8'hFF) begin
                            lost_nxt = lost_cnt + 8'd1;
                        end
                    end else begin
                        drop_cnt_nxt = drop_cnt + DROP_W'(1);
                    end
                end
            end
            ST_FAIL: begin
                if (clr_fail) begin
                    state_nxt = ST_RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = ST_RESET_PLL;
        endcase

        pll_rst_nxt = (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAIL);
        ad_rst_nxt  = (state_nxt != ST_RUN);
        lock_ok_nxt = (state_nxt == ST_RUN);
        fail_nxt    = (state_nxt == ST_FAIL);
    end

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clkin1) begin
        if (rst) begin
            sync_q   <= 1'b0;
            lock_s   <= 1'b0;
            state    <= ST_RESET_PLL;
            rst_cnt  <= '0;
            to_cnt   <= '0;
            set_cnt  <= '0;
            drop_cnt <= '0;
            retry    <= '0;
            lost_cnt <= '0;
            pll_rst  <= 1'b1;
            ad_rst   <= 1'b1;
            lock_ok  <= 1'b0;
            fail     <= 1'b0;
        end else begin
            sync_q   <= pll_lock;
            lock_s   <= sync_q;
            state    <= state_nxt;
            rst_cnt  <= rst_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            set_cnt  <= set_cnt_nxt;
            drop_cnt <= drop_cnt_nxt;
            retry    <= retry_nxt;
            lost_cnt <= lost_nxt;
            pll_rst  <= pll_rst_nxt;
            ad_rst   <= ad_rst_nxt;
            lock_ok  <= lock_ok_nxt;
            fail     <= fail_nxt;
        end
    end

endmodule
